masku_result_packer: RTL
========================

Name: masku_result_packer

Overview:
- Downstream of the mask-unit operand stage; consumes per-beat compressed compare/carry results (1 bit per element, already placed at the current bit pointer) and packs them into full deshuffled mask words.
- Drives the bit write pointer back to the compressor.
- Emits completed mask words, with byte enables, to the mask-unit VRF write path over a valid/ready handshake.

Parameters:
- NrLanes, 4, number of lanes; datapath width DW = NrLanes*ELEN bits.
- ELEN, 64, element width in bits; ELENB = ELEN/8.
- VLEN, 1024, vector length in bits; sizes the vl counter (VlW = log2(VLEN)+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_valid_i  in  1  new instruction request.
- start_ready_o  out  1  high only in IDLE.
- vl_i  in  VlW  element count; sampled on start handshake.
- eew_vs2_i  in  2  source EEW (vew_e: 0=8b … 3=64b); sampled on start handshake.
- beat_valid_i  in  1  compressed beat valid.
- beat_ready_o  out  1  beat accept; high only in ACCUM.
- beat_bits_i  in  DW  compressed bits; only window [pnt, pnt+n_eff) is meaningful.
- vrf_pnt_o  out  log2(DW)+1  current bit pointer (pnt).
- res_valid_o  out  1  packed word valid.
- res_ready_i  in  1  downstream accept.
- res_data_o  out  DW  packed mask word.
- res_be_o  out  DW/8  byte enables.
- res_last_o  out  1  final word of instruction.

Behaviour:
- Reset (async on rst_i rise, any state): state=IDLE; acc, pnt, remaining cleared; start_ready_o=1; all other outputs 0.
- Elements per beat: n = (NrLanes*ELENB) >> eew. n_eff = min(n, remaining).
- IDLE:
  - On start_valid_i&start_ready_o: latch eew, remaining=vl_i, pnt=0, acc=0.
  - vl_i==0 → stay IDLE; no output produced.
  - Otherwise → ACCUM.
- ACCUM, on beat handshake:
  - acc[pnt +: n_eff] = beat_bits_i[pnt +: n_eff]; bits outside the window are ignored.
  - pnt += n_eff; remaining -= n_eff.
  - If pnt==DW or remaining==0 → EMIT; otherwise stay ACCUM.
- EMIT:
  - res_valid_o=1; res_data_o=acc.
  - res_be_o[k]=1 iff byte k contains any bit below pnt.
  - res_last_o = (remaining==0).
  - All outputs held stable until res_ready_i.
  - beat_ready_o=0.
- On EMIT handshake: acc=0, pnt=0; if res_last_o → IDLE, else → ACCUM.
- Latency: res_valid_o asserts the cycle after the completing beat handshake. Throughput: one idle beat cycle per emitted word.
- pnt wraps DW→0 only on emit. It is never negative, and never exceeds DW.
- Simultaneous start request while not IDLE: ignored, because start_ready_o=0.
- Registered outputs: res_*, vrf_pnt_o, start_ready_o, beat_ready_o. All are decoded from registered state; no combinational path from inputs to outputs.

Optional Feature:
- Macro MASKU_PACK_TAIL_AGNOSTIC_EN.
- Defined: in the final word (res_last_o=1), bits ≥ pnt are forced to 1 and res_be_o is all ones (tail-agnostic fill).
- Undefined: tail bits are 0 and res_be_o covers only bytes containing written bits. Non-final words are identical in both builds.

Test Plan:
- NrLanes=4, eew=0, vl=64, two beats with beat_bits=all-ones → one word: res_data_o[63:0]=all-ones, upper bits 0, res_be_o=0x000000FF, res_last_o=1; vrf_pnt_o sequence 0, 32, 64, then 0.
- eew=3, vl=256: 64 beats of 4 bits (alternating pattern 0xA) → single word 0xAAAA…A, res_be_o all ones, last=1; vrf_pnt_o steps by 4.
- eew=0, vl=300: first word after 8 beats (be all ones, last=0); second word after 2 beats (32+12 bits), res_be_o=0x3F, last=1; beat bits above bit 43 in the 2nd beat are ignored.
- Backpressure: hold res_ready_i=0 for 5 cycles in EMIT → res_data_o/res_be_o stable; beat_ready_o=0; beats presented are not consumed.
- vl=0 start → res_valid_o never asserts; start_ready_o=1 the next cycle.
- Assert rst_i mid-ACCUM (after 3 beats) → outputs 0 and start_ready_o=1 immediately, without waiting for a clock edge; a new vl=32 instruction then yields a clean single word. With MASKU_PACK_TAIL_AGNOSTIC_EN: vl=40 eew=0 → res_data_o[255:40]=all-ones, res_be_o=all ones.

Source files
------------

// File: rtl/masku_result_packer.sv
// rtl/masku_result_packer.sv - packs compressed mask-unit result bits into VRF mask words
//
// Purpose: accumulates per-beat compressed compare/carry bits (one bit per
// element, already placed at the current bit pointer) into a DW-bit mask word,
// feeds the pointer back to the compressor, and emits finished words with
// byte enables over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_valid_i/ready_o new instruction handshake (vl_i, eew_vs2_i sampled)
//   beat_valid_i/ready_o  compressed beat handshake, beat_bits_i payload
//   vrf_pnt_o             current bit pointer into the word being packed
//   res_valid_o/ready_i   packed word handshake
//   res_data_o, res_be_o  packed mask word and its byte enables
//   res_last_o            final word of the instruction
//
// Optional: define MASKU_PACK_TAIL_AGNOSTIC_EN to fill the tail of the final
// word with ones and enable every byte of it.
module masku_result_packer #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned ELEN    = 64,
  parameter int unsigned VLEN    = 1024,
  localparam int unsigned DW     = NrLanes * ELEN,
  localparam int unsigned VlW    = $clog2(VLEN) + 1,
  localparam int unsigned PW     = $clog2(DW) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [VlW-1:0]    vl_i,
  input  logic [1:0]        eew_vs2_i,
  input  logic              beat_valid_i,
  output logic              beat_ready_o,
  input  logic [DW-1:0]     beat_bits_i,
  output logic [PW-1:0]     vrf_pnt_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DW-1:0]     res_data_o,
  output logic [DW/8-1:0]   res_be_o,
  output logic              res_last_o
);

  localparam int unsigned ELENB = ELEN / 8;
  localparam int unsigned NMAX  = NrLanes * ELENB;
  localparam int unsigned NW    = $clog2(NMAX) + 1;
  localparam logic [PW-1:0] PNT_FULL = PW'(DW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    pnt_q, pnt_d;
  logic [VlW-1:0]   rem_q, rem_d;
  logic [1:0]       eew_q, eew_d;

  logic [NW-1:0]    n_elem;
  logic [NW-1:0]    n_eff;
  logic [PW-1:0]    pnt_add;
  logic [VlW-1:0]   rem_sub;
  logic [DW-1:0]    win_mask;
  logic [DW-1:0]    tail_mask;
  logic [DW/8-1:0]  be_written;
  logic             is_last;

  // Elements per beat shrink with wider source elements.
  assign n_elem  = NW'(NMAX >> eew_q);
  assign pnt_add = pnt_q + PW'(n_eff);
  assign rem_sub = rem_q - VlW'(n_eff);
  assign is_last = (rem_q == '0);

  always_comb begin
    n_eff = n_elem;
    if (rem_q < VlW'(n_elem)) begin
      n_eff = NW'(rem_q);
    end
  end

  // Bit-granular masks derived from the pointer: the write window of the
  // current beat, the unwritten tail, and bytes touched by written bits.
  always_comb begin
    win_mask   = '0;
    tail_mask  = '0;
    be_written = '0;
    for (int i = 0; i < int'(DW); i++) begin
      win_mask[i]  = (i >= int'(pnt_q)) && (i < int'(pnt_q) + int'(n_eff));
      tail_mask[i] = (i >= int'(pnt_q));
    end
    for (int k = 0; k < int'(DW / 8); k++) begin
      be_written[k] = (int'(pnt_q) > 8 * k);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pnt_d   = pnt_q;
    rem_d   = rem_q;
    eew_d   = eew_q;
    case (state_q)
      IDLE: begin
        if (start_valid_i) begin
          eew_d = eew_vs2_i;
          rem_d = vl_i;
          pnt_d = '0;
          acc_d = '0;
          if (vl_i != '0) begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (beat_valid_i) begin
          acc_d = (acc_q & ~win_mask) | (beat_bits_i & win_mask);
          pnt_d = pnt_add;
          rem_d = rem_sub;
          if ((pnt_add == PNT_FULL) || (rem_sub == '0)) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (res_ready_i) begin
          acc_d   = '0;
          pnt_d   = '0;
          state_d = is_last ? IDLE : ACCUM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pnt_q   <= '0;
      rem_q   <= '0;
      eew_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pnt_q   <= pnt_d;
      rem_q   <= rem_d;
      eew_q   <= eew_d;
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    start_ready_o = (state_q == IDLE);
    beat_ready_o  = (state_q == ACCUM);
    vrf_pnt_o     = pnt_q;
    res_valid_o   = 1'b0;
    res_data_o    = '0;
    res_be_o      = '0;
    res_last_o    = 1'b0;
    if (state_q == EMIT) begin
      res_valid_o = 1'b1;
      res_last_o  = is_last;
`ifdef MASKU_PACK_TAIL_AGNOSTIC_EN
      res_data_o  = is_last ? (acc_q | tail_mask) : acc_q;
      res_be_o    = is_last ? '1 : be_written;
`else
      res_data_o  = acc_q;
      res_be_o    = be_written;
`endif
    end
  end

endmodule
